linebuf_reader: RTL and testbench

Read-side sequencer for a single line-buffer memory (registered read address, one-cycle read latency). On a start pulse it walks addresses 0..line_len-1, absorbs the memory's read latency, and presents the words as a valid/ready stream with full throughput under backpressure. It sits between a line buffer and the downstream window/convolution datapath, as the counterpart of the logic that fills the buffer.

---
 rtl/linebuf_reader_pkg.sv | 13 +
 rtl/linebuf_reader_if.sv | 29 ++
 rtl/linebuf_skid_fifo.sv | 58 +++++
 rtl/linebuf_reader.sv | 134 +++++++++++++
 tb/tb_linebuf_reader.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/linebuf_reader_pkg.sv
// linebuf_reader shared types: data width and read-sequencer FSM states.
// Imported by the interface, the skid FIFO and the top.
package linebuf_reader_pkg;

  localparam int DWIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/linebuf_reader_if.sv
// linebuf_reader bus: line command, line-buffer read port, output stream.
// slave = sequencer side, master = controller/memory/sink side.
interface linebuf_reader_if #(
  parameter int BSIZE = 5
);

  localparam int DW = linebuf_reader_pkg::DWIDTH;

  logic                 start;
  logic [BSIZE:0]       line_len;
  logic                 busy;
  logic                 done;
  logic [BSIZE-1:0]     mem_addr;
  logic signed [DW-1:0] read_data;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  start, line_len, read_data, out_ready,
    output busy, done, mem_addr, out_data, out_valid
  );

  modport master (
    output start, line_len, read_data, out_ready,
    input  busy, done, mem_addr, out_data, out_valid
  );

endinterface

// File: rtl/linebuf_skid_fifo.sv
// 2-entry registered FIFO; head kept in r_head so o_data is a flop.
// Ports: clk, rst, i_push/i_data, i_pop, o_data, o_valid, o_count.
module linebuf_skid_fifo
  import linebuf_reader_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic signed [DWIDTH-1:0] i_data,
  input  logic                     i_pop,
  output logic signed [DWIDTH-1:0] o_data,
  output logic                     o_valid,
  output logic [1:0]               o_count
);

  logic signed [DWIDTH-1:0] r_head;
  logic signed [DWIDTH-1:0] r_tail;
  logic [1:0]               r_count;
  logic                     w_pop;
  logic                     w_push;

  assign w_pop  = i_pop & (r_count != 2'd0);
  assign w_push = i_push & ((r_count != 2'd2) | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_data;
          else                 r_tail <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= i_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_data  = r_head;
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/linebuf_reader.sv
// Line-buffer read sequencer: walks 0..len-1, absorbs 1-cycle read
// latency, streams words valid/ready at full rate through a 2-deep skid.
// Ports: clk, rst (sync, high), bus (linebuf_reader_if.slave).
// LINEBUF_READER_ZERO_PAD_EN: emit one zero word before and after a line.
module linebuf_reader
  import linebuf_reader_pkg::*;
#(
  parameter int BSIZE = 5
) (
  input logic             clk,
  input logic             rst,
  linebuf_reader_if.slave bus
);

  localparam int CW = BSIZE + 2;

  state_t                   r_state;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_inflight;
  logic                     r_inflight_pad;
  logic [CW-1:0]            r_total;
  logic [CW-1:0]            r_slot;
  logic [BSIZE-1:0]         r_addr;
  logic [BSIZE-1:0]         r_mem_addr;

  logic [CW-1:0]            w_total;
  logic [1:0]               w_count;
  logic                     w_valid;
  logic signed [DWIDTH-1:0] w_data;
  logic signed [DWIDTH-1:0] w_push_data;
  logic                     w_pop;
  logic                     w_credit;
  logic                     w_issue;
  logic                     w_issue_rd;
  logic                     w_pad;
  logic                     w_last;
  logic                     w_drained;

  assign w_pop       = w_valid & bus.out_ready;
  assign w_push_data = r_inflight_pad ? '0 : bus.read_data;
  assign w_last      = (r_slot == r_total - CW'(1));

`ifdef LINEBUF_READER_ZERO_PAD_EN
  assign w_total = {1'b0, bus.line_len} + CW'(2);
  assign w_pad   = (r_slot == '0) | w_last;
`else
  assign w_total = {1'b0, bus.line_len};
  assign w_pad   = 1'b0;
`endif

  // Occupancy plus in-flight word may not exceed 2 after this cycle,
  // so a pop in the same cycle frees the slot for a new issue.
  always_comb begin
    w_credit = 1'b0;
    unique case ({w_count, r_inflight})
      3'b000, 3'b001, 3'b010: w_credit = 1'b1;
      3'b011, 3'b100:         w_credit = w_pop;
      default:                w_credit = 1'b0;
    endcase
  end

  assign w_issue    = (r_state == READ) & w_credit;
  assign w_issue_rd = w_issue & ~w_pad;

  // Looking one cycle ahead keeps done a flop yet lands it in the
  // first cycle the FIFO is empty with nothing in flight.
  assign w_drained = ~r_inflight &
    ((w_count == 2'd0) | ((w_count == 2'd1) & w_pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_inflight     <= 1'b0;
      r_inflight_pad <= 1'b0;
      r_total        <= '0;
      r_slot         <= '0;
      r_addr         <= '0;
      r_mem_addr     <= '0;
    end else begin
      r_inflight     <= w_issue;
      r_inflight_pad <= w_issue & w_pad;
      r_done         <= 1'b0;
      if (w_issue) r_slot <= r_slot + CW'(1);
      if (w_issue_rd) begin
        r_addr     <= r_addr + BSIZE'(1);
        r_mem_addr <= r_addr;
      end
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_total <= w_total;
            r_slot  <= '0;
            r_addr  <= '0;
            r_busy  <= 1'b1;
            r_state <= (w_total == '0) ? DRAIN : READ;
          end
        end
        READ: begin
          if (w_issue & w_last) r_state <= DRAIN;
        end
        DRAIN: begin
          if (r_done) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_drained) begin
            r_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  linebuf_skid_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_data),
    .o_valid (w_valid),
    .o_count (w_count)
  );

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.mem_addr  = w_issue_rd ? r_addr : r_mem_addr;
  assign bus.out_data  = w_data;
  assign bus.out_valid = w_valid;

endmodule

// File: tb/tb_linebuf_reader.sv
// Self-checking bench for linebuf_reader: expected stream built from
// the line contents, compared at each transfer with immediate asserts.
module tb_linebuf_reader;
  import linebuf_reader_pkg::*;

  localparam int BSIZE = 5;
  localparam int DEPTH = 1 << BSIZE;
`ifdef LINEBUF_READER_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  logic signed [DWIDTH-1:0] mem [DEPTH];

  linebuf_reader_if #(.BSIZE(BSIZE)) bus ();

  linebuf_reader #(.BSIZE(BSIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Line buffer: registered address, data one cycle later.
  always @(posedge clk) bus.read_data <= mem[bus.mem_addr];

  task automatic check(input string tag,
                       input logic signed [31:0] got,
                       input logic signed [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = DWIDTH'($urandom);
  endtask

  // mode: 0 ready high, 1 ready 1,0,0 pattern, 2 random ready.
  task automatic run_line(input int len, input int mode,
                          input bit timed, input bit restart);
    logic signed [DWIDTH-1:0] exp [$];
    logic signed [DWIDTH-1:0] prev_data;
    int  n, k, dones, done_cyc, first_cyc;
    bit  prev_stall, fin, r;
    exp = {};
    if (PAD) exp.push_back('0);
    for (int i = 0; i < len; i++) exp.push_back(mem[i]);
    if (PAD) exp.push_back('0);
    n = exp.size();
    k = 0; dones = 0; done_cyc = -1; first_cyc = -1;
    prev_stall = 1'b0; fin = 1'b0; prev_data = '0;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.line_len  = (BSIZE+1)'(len);
    bus.out_ready = 1'b1;
    for (int c = 1; c < 400 && !fin; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (restart && c == 2) begin
        bus.start    = 1'b1;
        bus.line_len = (BSIZE+1)'(len + 3);
      end
      if (prev_stall) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, prev_data);
      end
      unique case (mode)
        0:       r = 1'b1;
        1:       r = ((c - 1) % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (bus.out_valid && first_cyc < 0) first_cyc = c;
      if (bus.out_valid && r) begin
        if (exp.size() == 0) begin
          check("extra_word", 1, 0);
        end else begin
          check("data", bus.out_data, exp.pop_front());
          if (timed) check("word_cycle", c, 3 + k);
        end
        k++;
      end
      prev_stall    = bus.out_valid && !r;
      prev_data     = bus.out_data;
      bus.out_ready = r;
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        check("busy_fall", bus.busy, 0);
        fin = 1'b1;
      end
      if (bus.done) begin
        dones++;
        done_cyc = c;
        check("busy_at_done", bus.busy, 1);
      end
    end
    if (!fin) check("timeout", 0, 1);
    check("word_count", k, n);
    check("left_over", exp.size(), 0);
    check("done_pulses", dones, 1);
    if (timed) begin
      check("first_valid", first_cyc, (n == 0) ? -1 : 3);
      check("done_cycle", done_cyc, (n == 0) ? 2 : n + 3);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.line_len  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_addr", bus.mem_addr, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) mem[i] = DWIDTH'(10 + i);
    run_line(4, 0, 1'b1, 1'b0);

    fill_random();
    run_line(DEPTH, 0, 1'b1, 1'b0);

    fill_random();
    run_line(6, 1, 1'b0, 1'b0);

    fill_random();
    @(negedge clk);
    bus.start     = 1'b1;
    bus.line_len  = (BSIZE+1)'(8);
    bus.out_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_valid", bus.out_valid, 0);
    check("abort_data", bus.out_data, 0);
    check("abort_addr", bus.mem_addr, 0);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("abort_no_done", bus.done, 0);
      check("abort_idle", bus.busy, 0);
    end
    run_line(8, 0, 1'b1, 1'b0);

    run_line(0, 0, 1'b1, 1'b0);

    fill_random();
    run_line(3, 0, 1'b1, 1'b0);

    fill_random();
    run_line(5, 2, 1'b0, 1'b1);

    for (int t = 0; t < 6; t++) begin
      fill_random();
      run_line(int'($urandom_range(0, DEPTH)), 2, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
